// File: rtl/video_timing_detector.sv
// video_timing_detector: one-cycle DVI pixel pipeline with line/frame measurement and a lock FSM.
// Define TIMING_ERR_CNT_EN to build the saturating timing-error counter behind err_count.
module video_timing_detector #(
  parameter logic [10:0] EXP_HPIXELS = 11'd640,
  parameter logic [10:0] EXP_VLINES  = 11'd480,
  parameter int          LOCK_FRAMES = 2,
  parameter logic        SYNC_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de,
  input  logic        vsync,
  input  logic [23:0] pixel_in,
  output logic [23:0] pixel_out,
  output logic        pixel_valid,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [15:0] err_count
);
  localparam logic [1:0]  S_SEARCH  = 2'd0;
  localparam logic [1:0]  S_MEASURE = 2'd1;
  localparam logic [1:0]  S_LOCKED  = 2'd2;
  localparam logic [10:0] CNT_MAX   = 11'd2047;
  localparam logic [2:0]  LOCK_N    = 3'(LOCK_FRAMES);

  logic        r_de_d, r_vs_d;
  logic [23:0] r_pixel;
  logic        r_valid, r_line_start, r_frame_start, r_timing_err;
  logic [10:0] r_hcount, r_vcount, r_line;
  logic        r_armed, r_frame_ok;
  logic [1:0]  r_state;
  logic [2:0]  r_match;

  logic        w_vs_act, w_vs_edge, w_de_rise, w_de_fall;
  logic [11:0] w_width, w_lines;
  logic        w_width_bad, w_count_bad, w_frame_match, w_err, w_lock_hit;
  logic [2:0]  w_match_inc, w_match_nxt;
  logic [1:0]  w_state_nxt;

  assign w_vs_act  = vsync == SYNC_POL;
  assign w_vs_edge = w_vs_act && (r_vs_d != SYNC_POL);
  assign w_de_rise = de && !r_de_d;
  assign w_de_fall = !de && r_de_d;

  // r_hcount still holds the last pixel index on the de falling edge, so width is index + 1
  assign w_width       = {1'b0, r_hcount} + 12'd1;
  assign w_lines       = {1'b0, r_line} + {11'd0, w_de_fall};
  assign w_width_bad   = w_de_fall && (w_width != {1'b0, EXP_HPIXELS});
  assign w_count_bad   = w_lines != {1'b0, EXP_VLINES};
  assign w_frame_match = r_frame_ok && !w_width_bad && !w_count_bad;
  assign w_err         = (r_state == S_LOCKED) &&
                         (w_width_bad || (w_vs_edge && w_count_bad) || (de && w_vs_act));
  assign w_match_inc   = r_match + 3'd1;
  assign w_lock_hit    = w_match_inc >= LOCK_N;

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    if (w_err) begin
      w_state_nxt = S_SEARCH;
      w_match_nxt = 3'd0;
    end else if (w_vs_edge && r_state == S_SEARCH) begin
      w_state_nxt = S_MEASURE;
      w_match_nxt = 3'd0;
    end else if (w_vs_edge && r_state == S_MEASURE) begin
      w_state_nxt = (w_frame_match && w_lock_hit) ? S_LOCKED : S_MEASURE;
      w_match_nxt = (w_frame_match && !w_lock_hit) ? w_match_inc : 3'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_de_d        <= 1'b0;
      r_vs_d        <= ~SYNC_POL;
      r_pixel       <= 24'd0;
      r_valid       <= 1'b0;
      r_hcount      <= 11'd0;
      r_vcount      <= 11'd0;
      r_line        <= 11'd0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_armed       <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_timing_err  <= 1'b0;
      r_state       <= S_SEARCH;
      r_match       <= 3'd0;
    end else begin
      r_de_d        <= de;
      r_vs_d        <= vsync;
      r_pixel       <= pixel_in;
      r_valid       <= de;
      r_line_start  <= w_de_rise;
      r_frame_start <= w_de_rise && (w_vs_edge || r_armed);
      r_armed       <= w_de_rise ? 1'b0 : (w_vs_edge ? 1'b1 : r_armed);
      r_line        <= w_vs_edge ? 11'd0 : ((w_de_fall && r_line != CNT_MAX) ? r_line + 11'd1 : r_line);
      r_frame_ok    <= w_vs_edge ? 1'b1 : (w_width_bad ? 1'b0 : r_frame_ok);
      r_timing_err  <= w_err;
      r_state       <= w_state_nxt;
      r_match       <= w_match_nxt;
      if (de) begin
        r_hcount <= w_de_rise ? 11'd0 : ((r_hcount == CNT_MAX) ? CNT_MAX : r_hcount + 11'd1);
        r_vcount <= w_vs_edge ? 11'd0 : r_line;
      end
    end
  end

`ifdef TIMING_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err_cnt <= 16'd0;
    else if (w_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
  end
  assign err_count = r_err_cnt;
`else
  assign err_count = 16'd0;
`endif

  assign pixel_out   = r_pixel;
  assign pixel_valid = r_valid;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign locked      = r_state == S_LOCKED;
  assign timing_err  = r_timing_err;
endmodule

// File: tb/tb_video_timing_detector.sv
// tb_video_timing_detector: directed checks of pipeline, counters, lock FSM and reset on a 16x6 frame.
module tb_video_timing_detector;
  localparam int HP = 16;
  localparam int VL = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        de = 1'b0;
  logic        vsync = 1'b0;
  logic [23:0] pixel_in = 24'd0;
  logic [23:0] pixel_out;
  logic        pixel_valid, line_start, frame_start, locked, timing_err;
  logic [10:0] hcount, vcount;
  logic [15:0] err_count;

  int          tests = 0;
  int          failed = 0;
  int          fs_cnt = 0;
  logic [23:0] last_pix = 24'd0;
  logic [15:0] exp_err = 16'd0;

  video_timing_detector #(
    .EXP_HPIXELS(11'(HP)), .EXP_VLINES(11'(VL)), .LOCK_FRAMES(2), .SYNC_POL(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .de(de), .vsync(vsync), .pixel_in(pixel_in),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .hcount(hcount), .vcount(vcount),
    .line_start(line_start), .frame_start(frame_start), .locked(locked),
    .timing_err(timing_err), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (frame_start === 1'b1) fs_cnt <= fs_cnt + 1;

  task automatic cyc(input logic d, input logic v);
    de = d;
    vsync = v;
    pixel_in = 24'($urandom);
    last_pix = pixel_in;
    @(negedge clk);
  endtask

  task automatic vs_pulse();
    repeat (3) cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0);
  endtask

  task automatic send_line(input int w, input int l, input bit chk);
    for (int p = 0; p < w; p++) begin
      cyc(1'b1, 1'b0);
      if (chk && p == 0) begin
        tests++;
        if (hcount !== 11'd0 || vcount !== 11'(l) || line_start !== 1'b1 ||
            frame_start !== (l == 0) || pixel_valid !== 1'b1 || pixel_out !== last_pix) begin
          failed++;
          $display("FAIL first_pixel line %0d: h=%0d v=%0d ls=%b fs=%b pv=%b pix=%h, need h=0 v=%0d ls=1 fs=%b pv=1 pix=%h",
                   l, hcount, vcount, line_start, frame_start, pixel_valid, pixel_out, l, l == 0, last_pix);
        end
      end
    end
    repeat (4) cyc(1'b0, 1'b0);
  endtask

  task automatic frame_lines(input bit chk);
    for (int l = 0; l < VL; l++) send_line(HP, l, chk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if (pixel_valid !== 1'b0 || hcount !== 11'd0 || vcount !== 11'd0 || locked !== 1'b0 ||
        frame_start !== 1'b0 || timing_err !== 1'b0 || err_count !== 16'd0 || pixel_out !== 24'd0) begin
      failed++;
      $display("FAIL reset_state: pv=%b h=%0d v=%0d lk=%b fs=%b te=%b ec=%0d pix=%h, need all 0",
               pixel_valid, hcount, vcount, locked, frame_start, timing_err, err_count, pixel_out);
    end
    reset = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    tests++;
    if (locked !== 1'b0 || pixel_valid !== 1'b0) begin
      failed++;
      $display("FAIL idle_after_reset: lk=%b pv=%b, need 0 0", locked, pixel_valid);
    end
  endtask

  task automatic test_lock();
    int base;
    base = fs_cnt;
    vs_pulse();
    frame_lines(1'b1);
    vs_pulse();
    frame_lines(1'b1);
    tests++;
    if (fs_cnt != base + 2 || locked !== 1'b0) begin
      failed++;
      $display("FAIL lock_pre: fs=%0d lk=%b, need fs=%0d lk=0", fs_cnt - base, locked, 2);
    end
    cyc(1'b0, 1'b1);
    tests++;
    if (locked !== 1'b1) begin
      failed++;
      $display("FAIL lock_rise: lk=%b, need 1", locked);
    end
    repeat (2) cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0);
    frame_lines(1'b1);
    tests++;
    if (fs_cnt != base + 3 || locked !== 1'b1 || timing_err !== 1'b0) begin
      failed++;
      $display("FAIL lock_hold: fs=%0d lk=%b te=%b, need fs=3 lk=1 te=0", fs_cnt - base, locked, timing_err);
    end
  endtask

  task automatic test_short_line();
    vs_pulse();
    send_line(HP, 0, 1'b1);
    tests++;
    if (locked !== 1'b1 || timing_err !== 1'b0) begin
      failed++;
      $display("FAIL short_pre: lk=%b te=%b, need 1 0", locked, timing_err);
    end
    repeat (HP - 1) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    tests++;
    if (timing_err !== 1'b1 || locked !== 1'b0) begin
      failed++;
      $display("FAIL short_err: te=%b lk=%b, need 1 0", timing_err, locked);
    end
    cyc(1'b0, 1'b0);
`ifdef TIMING_ERR_CNT_EN
    exp_err = 16'd1;
`endif
    tests++;
    if (timing_err !== 1'b0 || locked !== 1'b0 || err_count !== exp_err) begin
      failed++;
      $display("FAIL short_after: te=%b lk=%b ec=%0d, need 0 0 %0d", timing_err, locked, err_count, exp_err);
    end
  endtask

  task automatic test_long_line();
    vs_pulse();
    frame_lines(1'b0);
    vs_pulse();
    frame_lines(1'b0);
    vs_pulse();
    tests++;
    if (locked !== 1'b1) begin
      failed++;
      $display("FAIL relock: lk=%b, need 1", locked);
    end
    repeat (2048) cyc(1'b1, 1'b0);
    tests++;
    if (hcount !== 11'd2047) begin
      failed++;
      $display("FAIL long_reach: h=%0d, need 2047", hcount);
    end
    repeat (52) cyc(1'b1, 1'b0);
    tests++;
    if (hcount !== 11'd2047 || locked !== 1'b1 || timing_err !== 1'b0) begin
      failed++;
      $display("FAIL long_sat: h=%0d lk=%b te=%b, need 2047 1 0", hcount, locked, timing_err);
    end
    cyc(1'b0, 1'b0);
`ifdef TIMING_ERR_CNT_EN
    exp_err = 16'd2;
`endif
    tests++;
    if (timing_err !== 1'b1 || locked !== 1'b0 || err_count !== exp_err) begin
      failed++;
      $display("FAIL long_err: te=%b lk=%b ec=%0d, need 1 0 %0d", timing_err, locked, err_count, exp_err);
    end
    repeat (3) cyc(1'b0, 1'b0);
  endtask

  task automatic test_coincident();
    send_line(5, 0, 1'b0);
    send_line(5, 0, 1'b0);
    cyc(1'b1, 1'b1);
    tests++;
    if (frame_start !== 1'b1 || hcount !== 11'd0 || vcount !== 11'd0 || line_start !== 1'b1) begin
      failed++;
      $display("FAIL coinc_first: fs=%b h=%0d v=%0d ls=%b, need 1 0 0 1", frame_start, hcount, vcount, line_start);
    end
    cyc(1'b1, 1'b0);
    tests++;
    if (frame_start !== 1'b0 || hcount !== 11'd1 || vcount !== 11'd0 || line_start !== 1'b0) begin
      failed++;
      $display("FAIL coinc_second: fs=%b h=%0d v=%0d ls=%b, need 0 1 0 0", frame_start, hcount, vcount, line_start);
    end
    repeat (4) cyc(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int base;
    vs_pulse();
    repeat (301) cyc(1'b1, 1'b0);
    tests++;
    if (hcount !== 11'd300 || pixel_valid !== 1'b1) begin
      failed++;
      $display("FAIL mid_pre: h=%0d pv=%b, need 300 1", hcount, pixel_valid);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (pixel_valid !== 1'b0 || hcount !== 11'd0 || vcount !== 11'd0 || pixel_out !== 24'd0 ||
        line_start !== 1'b0 || frame_start !== 1'b0 || locked !== 1'b0 || timing_err !== 1'b0 || err_count !== 16'd0) begin
      failed++;
      $display("FAIL async_reset: pv=%b h=%0d v=%0d pix=%h ls=%b fs=%b lk=%b te=%b ec=%0d, need all 0",
               pixel_valid, hcount, vcount, pixel_out, line_start, frame_start, locked, timing_err, err_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = fs_cnt;
    cyc(1'b1, 1'b0);
    tests++;
    if (pixel_valid !== 1'b1 || hcount !== 11'd0 || line_start !== 1'b1 || frame_start !== 1'b0) begin
      failed++;
      $display("FAIL post_reset_pix: pv=%b h=%0d ls=%b fs=%b, need 1 0 1 0", pixel_valid, hcount, line_start, frame_start);
    end
    repeat (9) cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0);
    send_line(8, 1, 1'b0);
    tests++;
    if (fs_cnt != base) begin
      failed++;
      $display("FAIL no_fs_before_vs: fs=%0d, need 0", fs_cnt - base);
    end
    vs_pulse();
    send_line(8, 0, 1'b1);
    tests++;
    if (fs_cnt != base + 1) begin
      failed++;
      $display("FAIL fs_after_vs: fs=%0d, need 1", fs_cnt - base);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short_line();
    test_long_line();
    test_coincident();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
